// File: rtl/rr_arbiter_reg.sv
// rr_arbiter_reg: round-robin arbiter with a registered valid/ready grant.
//
// The requester that follows the last transferred grant gets highest priority.
// The chosen grant is held stable until the consumer accepts it.
//
// Parameters:
//   WIDTH          number of requesters (>= 1)
//   SPLIT          group size used by the priority-to-one-hot trees (power of 2)
//   IMPLEMENTATION selects the tree architecture (0 = grouped scan, else two's complement)
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      request vector, one bit per requester
//   gnt_oht  registered one-hot grant
//   gnt_idx  registered binary index of the grant
//   gnt_vld  registered grant valid
//   gnt_rdy  consumer ready; the grant transfers when gnt_vld && gnt_rdy

// prio_oht_tree: keeps only the lowest set bit of vec.
module prio_oht_tree #(
   parameter int WIDTH          = 8,
   parameter int SPLIT          = 2,
   parameter int IMPLEMENTATION = 0
) (
   input  logic [WIDTH-1:0] vec,
   output logic [WIDTH-1:0] oht
);

   generate
      if (IMPLEMENTATION == 0) begin : g_grouped
         localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;

         logic [NG-1:0] grp_any;
         logic [NG-1:0] lower_grp;
         logic          seen;

         // Each group of SPLIT bits produces an "any" flag. A bit wins only if
         // no lower group and no lower bit inside its own group is set.
         always_comb begin
            grp_any   = '0;
            lower_grp = '0;
            oht       = '0;
            seen      = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
               grp_any[i/SPLIT] = grp_any[i/SPLIT] | vec[i];
            end
            for (int g = 1; g < NG; g++) begin
               lower_grp[g] = lower_grp[g-1] | grp_any[g-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
               if ((i % SPLIT) == 0) begin
                  seen = lower_grp[i/SPLIT];
               end
               oht[i] = vec[i] & ~seen;
               seen   = seen | vec[i];
            end
         end
      end else begin : g_twos
         // The two's complement of vec keeps only its lowest set bit.
         assign oht = vec & (~vec + {{(WIDTH-1){1'b0}}, 1'b1});
      end
   endgenerate

endmodule

module rr_arbiter_reg #(
   parameter int WIDTH          = 8,
   parameter int SPLIT          = 2,
   parameter int IMPLEMENTATION = 0
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [WIDTH-1:0]                         req,
   output logic [WIDTH-1:0]                         gnt_oht,
   output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] gnt_idx,
   output logic                                     gnt_vld,
   input  logic                                     gnt_rdy
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] base;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] mreq;
   logic [WIDTH-1:0] oht_masked;
   logic [WIDTH-1:0] oht_unmasked;
   logic [WIDTH-1:0] sel_oht;
   logic [IDX_W-1:0] sel_idx;
   logic             xfer;

   assign xfer    = (state == GRANT) && gnt_rdy;
   assign gnt_vld = (state == GRANT);

   // On a transfer, the next grant is chosen relative to the grant that is
   // leaving. This happens on the same edge where ptr picks up that index.
   assign base = xfer ? gnt_idx : ptr;

   // The mask keeps only indices strictly above base. When base is the top
   // index the mask is empty, and the unmasked tree provides the wrap-around.
   always_comb begin
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask[i] = (IDX_W'(i) > base);
      end
   end

   assign mreq = req & mask;

   prio_oht_tree #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION)
   ) u_tree_masked (
      .vec (mreq),
      .oht (oht_masked)
   );

   prio_oht_tree #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION)
   ) u_tree_unmasked (
      .vec (req),
      .oht (oht_unmasked)
   );

   assign sel_oht = (|mreq) ? oht_masked : oht_unmasked;

   // Convert the one-hot selection to a binary index.
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sel_oht[i]) begin
            sel_idx = sel_idx | IDX_W'(i);
         end
      end
   end

   // The grant registers change only when a new grant is loaded or the last
   // one leaves. A stalled grant stays frozen whatever req does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt_oht <= '0;
         gnt_idx <= '0;
         ptr     <= IDX_W'(WIDTH - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt_oht <= sel_oht;
                  gnt_idx <= sel_idx;
                  state   <= GRANT;
               end
            end
            default: begin
               if (gnt_rdy) begin
                  ptr <= gnt_idx;
                  if (|req) begin
                     gnt_oht <= sel_oht;
                     gnt_idx <= sel_idx;
                  end else begin
                     gnt_oht <= '0;
                     gnt_idx <= '0;
                     state   <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/rr_arbiter_reg.md
RR_ARBITER_REG -- requirements
Module: rr_arbiter_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of requesters; legal range is WIDTH >= 1.
REQ-002 SHALL have parameter SPLIT, default 2, giving the tree split factor forwarded to the internal priority-to-one-hot trees; it SHALL be a power of 2.
REQ-003 SHALL have parameter IMPLEMENTATION, default 0, forwarded unchanged to the internal priority-to-one-hot trees.
REQ-004 SHALL have local parameter IDX_W = max(1, clog2(WIDTH)).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-007 req  input  WIDTH  request vector; bit i set means requester i is requesting.
REQ-008 gnt_oht  output  WIDTH  registered one-hot grant.
REQ-009 gnt_idx  output  IDX_W  registered binary index of the set bit in gnt_oht.
REQ-010 gnt_vld  output  1  registered valid flag for the grant.
REQ-011 gnt_rdy  input  1  consumer ready; the grant transfers when gnt_vld and gnt_rdy are both 1.

Function
REQ-012 SHALL hold a pointer register ptr[IDX_W], the index of the last transferred grant.
REQ-013 SHALL compute mask = bits with index strictly greater than ptr, and masked request mreq = req & mask.
REQ-014 SHALL select the lowest set index of mreq when mreq != 0; otherwise it SHALL select the lowest set index of req (wrap-around).
REQ-015 SHALL implement the selection with two priority-to-one-hot tree instances (masked and unmasked), both using SPLIT and IMPLEMENTATION.
REQ-016 SHALL have two states: IDLE (gnt_vld = 0) and GRANT (gnt_vld = 1).
REQ-017 IDLE: if req != 0, SHALL load the selected grant into gnt_oht and gnt_idx and go to GRANT; otherwise SHALL stay in IDLE. Latency from req to gnt_vld is 1 cycle.
REQ-018 GRANT with gnt_rdy = 0: gnt_oht, gnt_idx and gnt_vld SHALL stay constant, even if req changes or the granted bit deasserts.
REQ-019 GRANT with gnt_rdy = 1 (transfer): ptr SHALL become gnt_idx.
REQ-020 On a transfer, if req != 0, the next grant SHALL be loaded in the same edge, selected with the mask derived from the just-transferred gnt_idx; the state stays GRANT, giving back-to-back grants at 1 per cycle.
REQ-021 On a transfer, if req = 0, the state SHALL go to IDLE.
REQ-022 When ptr = WIDTH-1 the mask is empty, so selection SHALL come from the unmasked request vector.
REQ-023 Only a transfer SHALL update ptr.
REQ-024 With WIDTH = 1: gnt_idx SHALL always be 0, and the block behaves as a 1-entry registered valid/ready stage.
REQ-025 In any window of WIDTH consecutive transfers with all requests continuously asserted, every requester SHALL be granted exactly once.
REQ-026 When gnt_vld = 0, gnt_oht SHALL be 0 and gnt_idx SHALL be 0.
REQ-027 gnt_oht SHALL always be all-zero or exactly one-hot, and when gnt_vld = 1, gnt_oht SHALL equal 1 << gnt_idx.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately, without waiting for a clock edge, force: state = IDLE, gnt_vld = 0, gnt_oht = 0, gnt_idx = 0, ptr = WIDTH-1.
REQ-029 On reset during GRANT, the pending grant SHALL be dropped; after release, the first grant follows REQ-017 with ptr = WIDTH-1, so the lowest requesting index wins.
REQ-030 After rst_n deasserts, the first grant can be registered on the first rising clk edge.

Verification (WIDTH = 4)
REQ-031 After reset, req = 4'b1010 with gnt_rdy = 1 held -> gnt_idx sequence 1, 3, 1, 3 on consecutive cycles; gnt_vld = 1 from cycle 1 on.
REQ-032 req = 4'b1111 with gnt_rdy = 1 -> gnt_oht sequence 0001, 0010, 0100, 1000, 0001 (wrap-around).
REQ-033 Grant of idx 2 is pending, gnt_rdy = 0 for 5 cycles while req changes to 4'b0001 -> gnt_oht stays 0100; when gnt_rdy = 1, the next grant is 0001.
REQ-034 Transfer of idx 3 with req = 4'b1000 only -> next grant is 1000 (unmasked fallback); transfer with req = 0 -> gnt_vld = 0 on the next cycle.
REQ-035 rst_n pulsed low asynchronously (mid-cycle) while gnt_vld = 1 and ptr = 2 -> outputs are zero before the next clock edge; after release, req = 4'b1111 gives first grant 0001.
REQ-036 Random req/gnt_rdy for 10k cycles -> the one-hot/index invariant (REQ-027), hold-while-stalled (REQ-018) and fairness (REQ-025) are checked every cycle.
